// File: rtl/lc3_pkg.sv
// Shared LC-3 control definitions: sequencer states, opcodes and datapath mux encodings.
package lc3_pkg;

  typedef enum logic [4:0] {
    HALTED, S18, S33, S35, S32,
    S01, S05, S09, S00, S22,
    S12, S04, S21, S06, S25,
    S27, S07, S23, S16, PAUSE1,
    PAUSE2
  } state_t;

  localparam logic [3:0] OP_BR    = 4'b0000;
  localparam logic [3:0] OP_ADD   = 4'b0001;
  localparam logic [3:0] OP_JSR   = 4'b0100;
  localparam logic [3:0] OP_AND   = 4'b0101;
  localparam logic [3:0] OP_LDR   = 4'b0110;
  localparam logic [3:0] OP_STR   = 4'b0111;
  localparam logic [3:0] OP_NOT   = 4'b1001;
  localparam logic [3:0] OP_JMP   = 4'b1100;
  localparam logic [3:0] OP_PAUSE = 4'b1101;

  localparam logic [1:0] PCMUX_PC1  = 2'b00;
  localparam logic [1:0] PCMUX_ADDR = 2'b01;
  localparam logic [1:0] PCMUX_BUS  = 2'b10;

  localparam logic [1:0] A2_ZERO  = 2'b00;
  localparam logic [1:0] A2_OFF6  = 2'b01;
  localparam logic [1:0] A2_OFF9  = 2'b10;
  localparam logic [1:0] A2_OFF11 = 2'b11;

  localparam logic [1:0] ALUK_ADD  = 2'b00;
  localparam logic [1:0] ALUK_AND  = 2'b01;
  localparam logic [1:0] ALUK_NOT  = 2'b10;
  localparam logic [1:0] ALUK_PASS = 2'b11;

endpackage

// File: rtl/mem_wait_ctr.sv
// Memory wait-state counter: counts cycles spent in an access state, flags the last one.
module mem_wait_ctr #(
  parameter int MEM_WAIT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic done
);
  localparam int CW = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(MEM_WAIT - 1);

  logic [CW-1:0] cnt;

  // Access states are never back to back, so dropping en doubles as the entry clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      cnt <= '0;
    else if (!en) cnt <= '0;
    else          cnt <= cnt + CW'(1);
  end

  assign done = (cnt == LAST);
endmodule

// File: rtl/isdu.sv
// LC-3 instruction sequencing/decode unit: Moore FSM driving every datapath control.
module isdu
  import lc3_pkg::*;
#(
  parameter int MEM_WAIT = 2
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Run,
  input  logic       Continue,
  input  logic [3:0] Opcode,
  input  logic       IR_5,
  input  logic       IR_11,
  input  logic       BEN,
  output logic       LD_MAR,
  output logic       LD_MDR,
  output logic       LD_IR,
  output logic       LD_BEN,
  output logic       LD_CC,
  output logic       LD_REG,
  output logic       LD_PC,
  output logic       LD_LED,
  output logic       GatePC,
  output logic       GateMDR,
  output logic       GateALU,
  output logic       GateMARMUX,
  output logic [1:0] PCMUX,
  output logic [1:0] ADDR2MUX,
  output logic [1:0] ALUK,
  output logic       DRMUX,
  output logic       SR1MUX,
  output logic       SR2MUX,
  output logic       ADDR1MUX,
  output logic       MIO_EN,
  output logic       Mem_OE,
  output logic       Mem_WE
);
  state_t state, next;
  logic   in_mem, mem_done, was_pause1;

  assign in_mem = (state == S33) || (state == S25) || (state == S16);

  mem_wait_ctr #(.MEM_WAIT(MEM_WAIT)) u_wait (
    .clk  (Clk),
    .rst  (Reset),
    .en   (in_mem),
    .done (mem_done)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state      <= HALTED;
      was_pause1 <= 1'b0;
    end else begin
      state      <= next;
      was_pause1 <= (state == PAUSE1);
    end
  end

  always_comb begin
    next       = state;
    LD_MAR     = 1'b0; LD_MDR  = 1'b0; LD_IR   = 1'b0; LD_BEN     = 1'b0;
    LD_CC      = 1'b0; LD_REG  = 1'b0; LD_PC   = 1'b0; LD_LED     = 1'b0;
    GatePC     = 1'b0; GateMDR = 1'b0; GateALU = 1'b0; GateMARMUX = 1'b0;
    PCMUX      = PCMUX_PC1;
    ADDR2MUX   = A2_ZERO;
    ALUK       = ALUK_ADD;
    DRMUX      = 1'b0; SR1MUX = 1'b0; SR2MUX = 1'b0; ADDR1MUX = 1'b0;
    MIO_EN     = 1'b0;
    Mem_OE     = 1'b1;
    Mem_WE     = 1'b1;
    unique case (state)
      HALTED: if (Run) next = S18;
      S18: begin
        GatePC = 1'b1; LD_MAR = 1'b1; LD_PC = 1'b1;
        next = S33;
      end
      S33, S25: begin
        Mem_OE = 1'b0; MIO_EN = 1'b1; LD_MDR = 1'b1;
        if (mem_done) next = (state == S33) ? S35 : S27;
      end
      S35: begin
        GateMDR = 1'b1; LD_IR = 1'b1;
        next = S32;
      end
      S32: begin
        LD_BEN = 1'b1;
        case (Opcode)
          OP_ADD:   next = S01;
          OP_AND:   next = S05;
          OP_NOT:   next = S09;
          OP_BR:    next = S00;
          OP_JMP:   next = S12;
          OP_JSR:   next = S04;
          OP_LDR:   next = S06;
          OP_STR:   next = S07;
          OP_PAUSE: next = PAUSE1;
          default:  next = S18;
        endcase
      end
      S01, S05, S09: begin
        SR1MUX = 1'b1; GateALU = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1;
        ALUK   = (state == S01) ? ALUK_ADD : (state == S05) ? ALUK_AND : ALUK_NOT;
        SR2MUX = (state == S09) ? 1'b0 : IR_5;
        next   = S18;
      end
      S00: next = BEN ? S22 : S18;
      S22: begin
        ADDR2MUX = A2_OFF9; PCMUX = PCMUX_ADDR; LD_PC = 1'b1;
        next = S18;
      end
      S12: begin
        SR1MUX = 1'b1; ADDR1MUX = 1'b1; PCMUX = PCMUX_ADDR; LD_PC = 1'b1;
        next = S18;
      end
      // R7 takes the already-incremented PC before S21 redirects it.
      S04: begin
        DRMUX = 1'b1; GatePC = 1'b1; LD_REG = 1'b1;
        next = S21;
      end
      S21: begin
        ADDR1MUX = ~IR_11;
        ADDR2MUX = IR_11 ? A2_OFF11 : A2_ZERO;
        PCMUX    = PCMUX_ADDR; LD_PC = 1'b1;
        next     = S18;
      end
      S06, S07: begin
        SR1MUX = 1'b1; ADDR1MUX = 1'b1; ADDR2MUX = A2_OFF6;
        GateMARMUX = 1'b1; LD_MAR = 1'b1;
        next = (state == S06) ? S25 : S23;
      end
      S27: begin
        GateMDR = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1;
        next = S18;
      end
      S23: begin
        ALUK = ALUK_PASS; GateALU = 1'b1; LD_MDR = 1'b1;
        next = S16;
      end
      S16: begin
        Mem_WE = 1'b0;
        if (mem_done) next = S18;
      end
      PAUSE1: begin
        LD_LED = ~was_pause1;
        if (Continue) next = PAUSE2;
      end
      PAUSE2: if (!Continue) next = S18;
      default: next = HALTED;
    endcase
  end
endmodule

// File: tb/tb_isdu.sv
// Directed cycle-by-cycle check of the isdu control word for each instruction class.
module tb_isdu;
  localparam int MW = 2;

  logic       Clk = 1'b0, Reset = 1'b1, Run = 1'b0, Continue = 1'b0;
  logic [3:0] Opcode = 4'b0000;
  logic       IR_5 = 1'b0, IR_11 = 1'b0, BEN = 1'b0;
  logic       LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
  logic       GatePC, GateMDR, GateALU, GateMARMUX;
  logic [1:0] PCMUX, ADDR2MUX, ALUK;
  logic       DRMUX, SR1MUX, SR2MUX, ADDR1MUX, MIO_EN, Mem_OE, Mem_WE;

  int checks = 0;
  int failures = 0;

  isdu #(.MEM_WAIT(MW)) dut (
    .Clk(Clk), .Reset(Reset), .Run(Run), .Continue(Continue),
    .Opcode(Opcode), .IR_5(IR_5), .IR_11(IR_11), .BEN(BEN),
    .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_BEN(LD_BEN),
    .LD_CC(LD_CC), .LD_REG(LD_REG), .LD_PC(LD_PC), .LD_LED(LD_LED),
    .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU), .GateMARMUX(GateMARMUX),
    .PCMUX(PCMUX), .ADDR2MUX(ADDR2MUX), .ALUK(ALUK),
    .DRMUX(DRMUX), .SR1MUX(SR1MUX), .SR2MUX(SR2MUX), .ADDR1MUX(ADDR1MUX),
    .MIO_EN(MIO_EN), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE)
  );

  always #5 Clk = ~Clk;

  logic [24:0] obs;
  assign obs = {LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
                GatePC, GateMDR, GateALU, GateMARMUX, PCMUX, ADDR2MUX, ALUK,
                DRMUX, SR1MUX, SR2MUX, ADDR1MUX, MIO_EN, Mem_OE, Mem_WE};

  localparam logic [24:0] B = 25'd1;
  localparam logic [24:0] LDMAR = B << 24, LDMDR = B << 23, LDIR  = B << 22, LDBEN = B << 21;
  localparam logic [24:0] LDCC  = B << 20, LDREG = B << 19, LDPC  = B << 18, LDLED = B << 17;
  localparam logic [24:0] GPC   = B << 16, GMDR  = B << 15, GALU  = B << 14, GMAR  = B << 13;
  localparam logic [24:0] P_ADR = 25'd1 << 11;
  localparam logic [24:0] A2_6  = 25'd1 << 9, A2_9 = 25'd2 << 9, A2_11 = 25'd3 << 9;
  localparam logic [24:0] K_AND = 25'd1 << 7, K_NOT = 25'd2 << 7, K_PASS = 25'd3 << 7;
  localparam logic [24:0] DR = B << 6, SR1 = B << 5, SR2 = B << 4, A1 = B << 3;
  localparam logic [24:0] MIO = B << 2, OE = B << 1, WE = B;
  localparam logic [24:0] DEF = OE | WE;

  localparam logic [24:0] E_S18  = DEF | LDMAR | LDPC | GPC;
  localparam logic [24:0] E_RD   = WE | MIO | LDMDR;
  localparam logic [24:0] E_S35  = DEF | GMDR | LDIR;
  localparam logic [24:0] E_S32  = DEF | LDBEN;
  localparam logic [24:0] E_OPR  = DEF | SR1 | GALU | LDREG | LDCC;
  localparam logic [24:0] E_S22  = DEF | A2_9 | P_ADR | LDPC;
  localparam logic [24:0] E_S12  = DEF | SR1 | A1 | P_ADR | LDPC;
  localparam logic [24:0] E_S04  = DEF | DR | GPC | LDREG;
  localparam logic [24:0] E_MAR  = DEF | SR1 | A1 | A2_6 | GMAR | LDMAR;
  localparam logic [24:0] E_S27  = DEF | GMDR | LDREG | LDCC;
  localparam logic [24:0] E_S23  = DEF | K_PASS | GALU | LDMDR;

  task automatic check(input string tag, input logic [24:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    checks++;
    assert (($countones({GatePC, GateMDR, GateALU, GateMARMUX}) <= 1) && (Mem_OE || Mem_WE)) else begin
      failures++;
      $error("FAIL %s_invariant gates=%b oe=%b we=%b required one-hot-or-zero gates and not both strobes",
             tag, {GatePC, GateMDR, GateALU, GateMARMUX}, Mem_OE, Mem_WE);
    end
  endtask

  task automatic cyc(input string tag, input logic [24:0] exp);
    @(posedge Clk); #1;
    check(tag, exp);
  endtask

  task automatic fetch(input logic [3:0] op);
    Opcode = op;
    for (int i = 0; i < MW; i++) cyc("S33", E_RD);
    cyc("S35", E_S35);
    cyc("S32", E_S32);
  endtask

  initial begin
    #1 check("reset_held", DEF);
    #12 Reset = 1'b0;
    // Reset asserted asynchronously in the middle of an instruction read
    Run = 1'b1;
    cyc("run_S18", E_S18);
    Run = 1'b0;
    cyc("pre_S33", E_RD);
    Reset = 1'b1; #1;
    check("async_reset", DEF);
    #1 Reset = 1'b0;
    for (int i = 0; i < 10; i++) cyc("halted", DEF);

    // ADD with imm5
    Run = 1'b1; IR_5 = 1'b1;
    cyc("add_S18", E_S18);
    Run = 1'b0;
    fetch(4'b0001);
    cyc("S01", E_OPR | SR2);
    cyc("add_S18b", E_S18);

    // AND register form, Run held high (ignored outside HALTED)
    Run = 1'b1; IR_5 = 1'b0;
    fetch(4'b0101);
    cyc("S05", E_OPR | K_AND);
    cyc("and_S18", E_S18);
    Run = 1'b0;

    // NOT with IR_5=1: SR2MUX stays 0
    IR_5 = 1'b1;
    fetch(4'b1001);
    cyc("S09", E_OPR | K_NOT);
    cyc("not_S18", E_S18);

    // BR not taken / taken
    BEN = 1'b0;
    fetch(4'b0000);
    cyc("S00_nt", DEF);
    cyc("br_nt_S18", E_S18);
    BEN = 1'b1;
    fetch(4'b0000);
    cyc("S00_t", DEF);
    cyc("S22", E_S22);
    cyc("br_t_S18", E_S18);

    // JMP
    fetch(4'b1100);
    cyc("S12", E_S12);
    cyc("jmp_S18", E_S18);

    // JSR (IR_11=1) then JSRR (IR_11=0)
    IR_11 = 1'b1;
    fetch(4'b0100);
    cyc("S04_jsr", E_S04);
    cyc("S21_jsr", DEF | A2_11 | P_ADR | LDPC);
    cyc("jsr_S18", E_S18);
    IR_11 = 1'b0;
    fetch(4'b0100);
    cyc("S04_jsrr", E_S04);
    cyc("S21_jsrr", DEF | A1 | P_ADR | LDPC);
    cyc("jsrr_S18", E_S18);

    // LDR
    fetch(4'b0110);
    cyc("S06", E_MAR);
    for (int i = 0; i < MW; i++) cyc("S25", E_RD);
    cyc("S27", E_S27);
    cyc("ldr_S18", E_S18);

    // STR: write strobe exactly MW cycles
    fetch(4'b0111);
    cyc("S07", E_MAR);
    cyc("S23", E_S23);
    for (int i = 0; i < MW; i++) cyc("S16", OE);
    cyc("str_S18", E_S18);

    // Unimplemented opcode acts as NOP
    fetch(4'b1111);
    cyc("nop_S18", E_S18);

    // PAUSE with Continue 0 -> 1 -> 0
    Continue = 1'b0;
    fetch(4'b1101);
    cyc("pause1_entry", DEF | LDLED);
    cyc("pause1_wait", DEF);
    Continue = 1'b1;
    cyc("pause2_a", DEF);
    cyc("pause2_b", DEF);
    cyc("pause2_c", DEF);
    Continue = 1'b0;
    cyc("pause_S18", E_S18);

    // PAUSE with Continue already high: still needs release
    Continue = 1'b1;
    fetch(4'b1101);
    cyc("pause1_hi", DEF | LDLED);
    for (int i = 0; i < 4; i++) cyc("pause2_stuck", DEF);
    Continue = 1'b0;
    cyc("pause_rel_S18", E_S18);
    fetch(4'b1111);
    cyc("final_S18", E_S18);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
